// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and
// fixed constants for PC stepping, NOP insertion and opcode extraction.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned PC_INCR    = 4;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, and an
// empty cycle without stall inserts a NOP bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   stall,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] load_instr,
  input  logic [PC_WIDTH-1:0]    load_pc4,
  output logic                   valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc4
);

  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc4_q,   pc4_d;

  // pc4 is left untouched on flush/bubble; only valid and instr are cleared
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = INSTR_WIDTH'(NOP_INSTR);
    end else if (stall) begin
      valid_d = valid_q;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc4_d   = load_pc4;
    end else begin
      valid_d = 1'b0;
      instr_d = INSTR_WIDTH'(NOP_INSTR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= INSTR_WIDTH'(NOP_INSTR);
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding memory request FSM,
// skid buffer for decode stalls and redirect handling feeding IF/ID.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [5:0]             if_id_opcode,
  output logic [PC_WIDTH-1:0]    if_id_pc4
);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0]    skid_pc4_q, skid_pc4_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [PC_WIDTH-1:0]    saved_target_q, saved_target_d;

  logic [PC_WIDTH-1:0]    pc_plus4;
  logic                   load_valid;
  logic [INSTR_WIDTH-1:0] load_instr;
  logic [PC_WIDTH-1:0]    load_pc4;

  assign pc_plus4 = pc_q + PC_WIDTH'(PC_INCR);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    skid_instr_d   = skid_instr_q;
    skid_pc4_d     = skid_pc4_q;
    skid_valid_d   = skid_valid_q;
    saved_target_d = saved_target_q;
    imem_req       = 1'b0;
    load_valid     = 1'b0;
    load_instr     = imem_rdata;
    load_pc4       = pc_plus4;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (branch_taken) pc_d = branch_target;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          if (imem_rvalid) begin
            pc_d = branch_target;
          end else begin
            saved_target_d = branch_target;
            state_d        = S_DRAIN;
          end
        end else if (imem_rvalid) begin
          if (!stall) begin
            load_valid = 1'b1;
            pc_d       = pc_plus4;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            skid_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end
      end

      // pc still points at the skidded instruction until it is handed on
      S_HOLD: begin
        if (branch_taken) begin
          skid_valid_d = 1'b0;
          pc_d         = branch_target;
          state_d      = S_FETCH;
        end else if (!stall) begin
          load_valid   = skid_valid_q;
          load_instr   = skid_instr_q;
          load_pc4     = skid_pc4_q;
          skid_valid_d = 1'b0;
          pc_d         = pc_plus4;
          state_d      = S_FETCH;
        end
      end

      // A redirect arriving with the response takes precedence over the saved one
      S_DRAIN: begin
        imem_req = 1'b1;
        if (branch_taken) saved_target_d = branch_target;
        if (imem_rvalid) begin
          pc_d    = branch_taken ? branch_target : saved_target_q;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      skid_instr_q   <= INSTR_WIDTH'(NOP_INSTR);
      skid_pc4_q     <= '0;
      skid_valid_q   <= 1'b0;
      saved_target_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc4_q     <= skid_pc4_d;
      skid_valid_q   <= skid_valid_d;
      saved_target_q <= saved_target_d;
    end
  end

  assign imem_addr = pc_q;

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (branch_taken),
    .stall      (stall),
    .load       (load_valid),
    .load_instr (load_instr),
    .load_pc4   (load_pc4),
    .valid      (if_id_valid),
    .instr      (if_id_instr),
    .pc4        (if_id_pc4)
  );

  assign if_id_opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];

endmodule
